// File: rtl/dev_bridge_pkg.sv
// dev_bridge_pkg
//   Shared constants for the CPU-to-device bridge: address map region bounds,
//   device slot geometry, bridge register offsets, interrupt vector width, the
//   decode region type and two small address helpers.
//   No ports (package).
package dev_bridge_pkg;

    // Address map regions (inclusive bounds)
    localparam logic [31:0] DM_LO       = 32'h0000_0000;
    localparam logic [31:0] DM_HI       = 32'h0000_2fff;
    localparam logic [31:0] IM_LO       = 32'h0000_3000;
    localparam logic [31:0] IM_HI       = 32'h0000_6fff;
    localparam logic [31:0] BREG_LO     = 32'h0000_7f80;
    localparam logic [31:0] BREG_HI     = 32'h0000_7f8f;

    // Device slot geometry: slots are 16 bytes apart, 3 words decoded each
    localparam logic [31:0] SLOT_STRIDE = 32'd16;
    localparam logic [31:0] SLOT_SPAN   = 32'd12;

    // Bridge register byte offsets within BREG_LO..BREG_HI
    localparam logic [3:0]  OFF_PEND    = 4'h0;
    localparam logic [3:0]  OFF_CLR     = 4'h4;
    localparam logic [3:0]  OFF_MASK    = 4'h8;
    localparam logic [3:0]  OFF_ERR     = 4'hc;

    // CPU interrupt vector width
    localparam int          HW_INT_W    = 6;

    typedef enum logic [2:0] {
        RGN_NONE,
        RGN_DM,
        RGN_IM,
        RGN_DEV,
        RGN_BREG
    } region_e;

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    function automatic logic [31:0] slot_base(input logic [31:0] base,
                                              input int unsigned n);
        return base + SLOT_STRIDE * 32'(n);
    endfunction

endpackage

// File: rtl/dev_bridge_irq_capture.sv
// irq_capture
//   Pending-bit logic for one device interrupt line.
//   EDGE = 1: a 0->1 transition of irq_in sets pend one cycle later; pend then
//             holds until clr, and a same-cycle set beats clr.
//   EDGE = 0: pend is irq_in delayed by one cycle; clr is ignored.
// Ports:
//   clk     in  clock
//   reset   in  synchronous, active-high
//   irq_in  in  device interrupt line
//   clr     in  write-1-to-clear pulse for this slot
//   pend    out registered pending bit
module irq_capture #(
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic clr,
    output logic pend
);

    logic prev_q, prev_d;
    logic pend_q, pend_d;

    always_comb begin
        prev_d = irq_in;
        if (EDGE) begin
            pend_d = (irq_in & ~prev_q) | (pend_q & ~clr);
        end else begin
            pend_d = irq_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

endmodule

// File: rtl/dev_bridge.sv
// dev_bridge
//   Address decoder / bridge between a simple CPU port and data memory (DM),
//   instruction memory (IM), NUM_DEV timer-class device slots and a small
//   block of bridge registers (PEND, CLR, MASK, ERR_ADDR). Also builds the
//   registered CPU interrupt vector hw_int.
//
//   Bus: single-cycle, never stalls. A cycle with pr_rd_en high is a read, a
//   cycle with nonzero pr_byteen is a write; read data for the address
//   presented in cycle t is on pr_rdata in cycle t+1 (0 if unmapped or no read).
//
//   Optional feature macro: DEV_BRIDGE_ERR_EN -- unmapped accesses pulse
//   bus_err for one cycle and latch the address into ERR_ADDR. Undefined:
//   bus_err is 0 and ERR_ADDR reads 0.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   pr_addr/pr_byteen/pr_rd_en/pr_wdata   CPU request
//   pr_rdata                registered CPU read data
//   im_rdata, dm_rdata      memory read data
//   dm_byteen               byte enables forwarded to DM (DM region only)
//   dev_rdata               NUM_DEV x 32 device read data, slot n at [32n+:32]
//   dev_we                  one-hot per-slot write strobe
//   dev_wdata               write data to devices
//   irq_in                  device interrupt lines
//   ext_int                 external level interrupt
//   hw_int                  {zeros, ext_q, PEND & MASK}
//   bus_err                 unmapped-access pulse
module dev_bridge
    import dev_bridge_pkg::*;
#(
    parameter int                 NUM_DEV  = 2,
    parameter logic [31:0]        DEV_BASE = 32'h0000_7f00,
    parameter logic [NUM_DEV-1:0] IRQ_EDGE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             pr_addr,
    input  logic [3:0]              pr_byteen,
    input  logic                    pr_rd_en,
    input  logic [31:0]             pr_wdata,
    output logic [31:0]             pr_rdata,
    input  logic [31:0]             im_rdata,
    input  logic [31:0]             dm_rdata,
    output logic [3:0]              dm_byteen,
    input  logic [NUM_DEV*32-1:0]   dev_rdata,
    output logic [NUM_DEV-1:0]      dev_we,
    output logic [31:0]             dev_wdata,
    input  logic [NUM_DEV-1:0]      irq_in,
    input  logic                    ext_int,
    output logic [HW_INT_W-1:0]     hw_int,
    output logic                    bus_err
);

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    region_e             region;
    logic [NUM_DEV-1:0]  slot_hit;
    logic                is_wr;
    logic [3:0]          breg_off;

    always_comb begin
        slot_hit = '0;
        for (int unsigned n = 0; n < NUM_DEV; n++) begin
            if (in_range(pr_addr, slot_base(DEV_BASE, n),
                         slot_base(DEV_BASE, n) + SLOT_SPAN - 32'd1)) begin
                slot_hit[n] = 1'b1;
            end
        end

        if (in_range(pr_addr, DM_LO, DM_HI)) begin
            region = RGN_DM;
        end else if (in_range(pr_addr, IM_LO, IM_HI)) begin
            region = RGN_IM;
        end else if (in_range(pr_addr, BREG_LO, BREG_HI)) begin
            region = RGN_BREG;
        end else if (|slot_hit) begin
            region = RGN_DEV;
        end else begin
            region = RGN_NONE;
        end

        is_wr    = |pr_byteen;
        breg_off = pr_addr[3:0] & 4'hc;
    end

    assign dm_byteen = (region == RGN_DM) ? pr_byteen : 4'h0;
    assign dev_we    = (region == RGN_DEV && is_wr) ? slot_hit : '0;
    assign dev_wdata = pr_wdata;

    // ------------------------------------------------------------------
    // Bridge registers and interrupt capture
    // ------------------------------------------------------------------
    logic [NUM_DEV-1:0]  mask_q, mask_d;
    logic [NUM_DEV-1:0]  clr_vec;
    logic [NUM_DEV-1:0]  pend_vec;
    logic                ext_q, ext_d;
    logic [HW_INT_W-1:0] hw_int_q, hw_int_d;
    logic [31:0]         err_word;

    always_comb begin
        mask_d  = mask_q;
        clr_vec = '0;
        if (region == RGN_BREG && is_wr) begin
            // Any nonzero byte enable writes the whole word.
            if (breg_off == OFF_MASK) begin
                mask_d = pr_wdata[NUM_DEV-1:0];
            end
            if (breg_off == OFF_CLR) begin
                clr_vec = pr_wdata[NUM_DEV-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_DEV; g++) begin : g_irq
        irq_capture #(
            .EDGE (IRQ_EDGE[g])
        ) u_cap (
            .clk    (clk),
            .reset  (reset),
            .irq_in (irq_in[g]),
            .clr    (clr_vec[g]),
            .pend   (pend_vec[g])
        );
    end

    // hw_int is built only from flops so irq_in has no combinational path out.
    always_comb begin
        ext_d                 = ext_int;
        hw_int_d              = '0;
        hw_int_d[NUM_DEV-1:0] = pend_vec & mask_q;
        hw_int_d[NUM_DEV]     = ext_q;
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] dev_word;
    logic [31:0] pend_word;
    logic [31:0] mask_word;
    logic [31:0] breg_word;

    always_comb begin
        dev_word = '0;
        for (int n = 0; n < NUM_DEV; n++) begin
            if (slot_hit[n]) begin
                dev_word = dev_rdata[32*n +: 32];
            end
        end

        // PEND reads the flop value, i.e. before any same-cycle update.
        pend_word              = '0;
        pend_word[NUM_DEV-1:0] = pend_vec;
        mask_word              = '0;
        mask_word[NUM_DEV-1:0] = mask_q;

        case (breg_off)
            OFF_PEND: breg_word = pend_word;
            OFF_MASK: breg_word = mask_word;
            OFF_ERR:  breg_word = err_word;
            default:  breg_word = '0;
        endcase

        rdata_d = '0;
        if (pr_rd_en) begin
            case (region)
                RGN_DM:   rdata_d = dm_rdata;
                RGN_IM:   rdata_d = im_rdata;
                RGN_DEV:  rdata_d = dev_word;
                RGN_BREG: rdata_d = breg_word;
                default:  rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q  <= '0;
            mask_q   <= '1;
            ext_q    <= 1'b0;
            hw_int_q <= '0;
        end else begin
            rdata_q  <= rdata_d;
            mask_q   <= mask_d;
            ext_q    <= ext_d;
            hw_int_q <= hw_int_d;
        end
    end

    assign pr_rdata = rdata_q;
    assign hw_int   = hw_int_q;

    // ------------------------------------------------------------------
    // Unmapped-access reporting
    // ------------------------------------------------------------------
`ifdef DEV_BRIDGE_ERR_EN
    logic        err_hit;
    logic        bus_err_q, bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    always_comb begin
        err_hit    = (region == RGN_NONE) && (pr_rd_en || is_wr);
        bus_err_d  = err_hit;
        // Most recent error overwrites the captured address.
        err_addr_d = err_hit ? pr_addr : err_addr_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus_err  = bus_err_q;
    assign err_word = err_addr_q;
`else
    assign bus_err  = 1'b0;
    assign err_word = '0;
`endif

endmodule

// File: tb/tb_dev_bridge.sv
// tb_dev_bridge
//   Directed bench for dev_bridge (NUM_DEV = 2, slot 0 edge, slot 1 level).
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   in the same window, away from the edge.
module tb_dev_bridge;

    localparam int NUM_DEV = 2;
`ifdef DEV_BRIDGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0]           pr_addr;
    logic [3:0]            pr_byteen;
    logic                  pr_rd_en;
    logic [31:0]           pr_wdata;
    logic [31:0]           pr_rdata;
    logic [31:0]           im_rdata;
    logic [31:0]           dm_rdata;
    logic [3:0]            dm_byteen;
    logic [NUM_DEV*32-1:0] dev_rdata;
    logic [NUM_DEV-1:0]    dev_we;
    logic [31:0]           dev_wdata;
    logic [NUM_DEV-1:0]    irq_in;
    logic                  ext_int;
    logic [5:0]            hw_int;
    logic                  bus_err;

    dev_bridge #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (32'h0000_7f00),
        .IRQ_EDGE (2'b01)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pr_addr   (pr_addr),
        .pr_byteen (pr_byteen),
        .pr_rd_en  (pr_rd_en),
        .pr_wdata  (pr_wdata),
        .pr_rdata  (pr_rdata),
        .im_rdata  (im_rdata),
        .dm_rdata  (dm_rdata),
        .dm_byteen (dm_byteen),
        .dev_rdata (dev_rdata),
        .dev_we    (dev_we),
        .dev_wdata (dev_wdata),
        .irq_in    (irq_in),
        .ext_int   (ext_int),
        .hw_int    (hw_int),
        .bus_err   (bus_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        pr_addr   = 32'h0;
        pr_byteen = 4'h0;
        pr_rd_en  = 1'b0;
        pr_wdata  = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        pr_addr   = addr;
        pr_wdata  = data;
        pr_byteen = be;
        pr_rd_en  = 1'b0;
        step();
        bus_idle();
    endtask

    task automatic read_chk(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp);
        exp_q.push_back(exp);
        pr_addr   = addr;
        pr_byteen = 4'h0;
        pr_rd_en  = 1'b1;
        step();
        bus_idle();
        check(tag, pr_rdata, exp_q.pop_front());
    endtask

    // Watchdog: the sequence is fixed-length, this only guards a stuck clock.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bus_idle();
        irq_in    = '0;
        ext_int   = 1'b0;
        dev_rdata = {32'h1111_2222, 32'hDEAD_BEEF};
        im_rdata  = 32'h1234_5678;
        dm_rdata  = 32'hCAFE_F00D;
        reset     = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_rdata",  pr_rdata,        32'h0);
        check("rst_hw_int", 32'(hw_int),     32'h0);
        check("rst_bus_err", 32'(bus_err),   32'h0);
        check("rst_dm_be",  32'(dm_byteen),  32'h0);
        read_chk("rst_mask", 32'h7f88, 32'h3);
        read_chk("rst_pend", 32'h7f80, 32'h0);
        read_chk("rst_err",  32'h7f8c, 32'h0);

        // Slot 0 read, no write strobe
        pr_addr  = 32'h7f04;
        pr_rd_en = 1'b1;
        #1;
        check("rd_dev_we", 32'(dev_we), 32'h0);
        step();
        bus_idle();
        check("rd_slot0", pr_rdata, 32'hDEAD_BEEF);
        step();
        check("rd_idle_zero", pr_rdata, 32'h0);

        // Read map including window edges
        read_chk("rd_slot1",      32'h7f14, 32'h1111_2222);
        read_chk("rd_slot0_last", 32'h7f0b, 32'hDEAD_BEEF);
        read_chk("rd_slot0_gap",  32'h7f0c, 32'h0);
        read_chk("rd_im_lo",      32'h3000, 32'h1234_5678);
        read_chk("rd_im_hi",      32'h6ffc, 32'h1234_5678);
        read_chk("rd_dm_hi",      32'h2ffc, 32'hCAFE_F00D);
        read_chk("rd_unmapped",   32'h7000, 32'h0);
        read_chk("rd_clr_zero",   32'h7f84, 32'h0);

        // Write strobe routing (combinational)
        pr_addr = 32'h0000_1000; pr_byteen = 4'h3; #1;
        check("wr_dm_be",     32'(dm_byteen), 32'h3);
        check("wr_dm_dev_we", 32'(dev_we),    32'h0);
        pr_addr = 32'h7f10; #1;
        check("wr_s1_dm_be",  32'(dm_byteen), 32'h0);
        check("wr_s1_dev_we", 32'(dev_we),    32'h2);
        pr_addr = 32'h7f08; pr_byteen = 4'hf; #1;
        check("wr_s0_dev_we", 32'(dev_we),    32'h1);
        pr_addr = 32'h7f0c; #1;
        check("wr_gap_dev_we", 32'(dev_we),   32'h0);
        bus_idle();
        step();

        // Edge slot 0: one-cycle pulse
        irq_in[0] = 1'b1;
        step();
        irq_in[0] = 1'b0;
        check("edge_hw_t1", 32'(hw_int), 32'h0);
        step();
        check("edge_hw_t2", 32'(hw_int), 32'h1);
        step();
        step();
        check("edge_hw_hold", 32'(hw_int), 32'h1);
        read_chk("edge_pend", 32'h7f80, 32'h1);

        // Clear: pend drops next cycle, hw_int one cycle after that
        pr_addr = 32'h7f84; pr_wdata = 32'h1; pr_byteen = 4'hf;
        step();
        bus_idle();
        check("clr_hw_t1", 32'(hw_int), 32'h1);
        step();
        check("clr_hw_t2", 32'(hw_int), 32'h0);
        read_chk("clr_pend", 32'h7f80, 32'h0);

        // Same-cycle rise and clear: set wins
        irq_in[0] = 1'b1;
        pr_addr = 32'h7f84; pr_wdata = 32'h1; pr_byteen = 4'hf;
        step();
        bus_idle();
        read_chk("set_wins", 32'h7f80, 32'h1);
        bus_write(32'h7f84, 32'h1, 4'h1);
        irq_in[0] = 1'b0;
        read_chk("set_wins_clr", 32'h7f80, 32'h0);

        // Level slot 1 with MASK = 0
        bus_write(32'h7f88, 32'h0, 4'hf);
        irq_in[1] = 1'b1;
        step();
        step();
        read_chk("lvl_pend", 32'h7f80, 32'h2);
        check("lvl_masked_hw", 32'(hw_int), 32'h0);
        read_chk("mask_zero", 32'h7f88, 32'h0);

        // External interrupt: two-cycle latency to hw_int[2]
        ext_int = 1'b1;
        step();
        check("ext_hw_t1", 32'(hw_int), 32'h0);
        step();
        check("ext_hw_t2", 32'(hw_int), 32'h4);

        // CLR and RO writes do not touch level pend; ERR_ADDR is RO
        bus_write(32'h7f84, 32'h2, 4'hf);
        read_chk("lvl_noclr", 32'h7f80, 32'h2);
        bus_write(32'h7f80, 32'h0, 4'hf);
        read_chk("pend_ro", 32'h7f80, 32'h2);
        bus_write(32'h7f8c, 32'hffff_ffff, 4'h8);
        read_chk("err_ro", 32'h7f8c, 32'h0);

        // Unmask: hw_int = {ext, pend1, pend0} = 3'b110
        bus_write(32'h7f88, 32'hffff_ffff, 4'h1);
        step();
        check("unmask_hw", 32'(hw_int), 32'h6);
        read_chk("mask_width", 32'h7f88, 32'h3);

        // Level drop follows input
        irq_in[1] = 1'b0;
        step();
        step();
        check("lvl_drop_hw", 32'(hw_int), 32'h4);
        ext_int = 1'b0;
        step();
        step();
        check("ext_drop_hw", 32'(hw_int), 32'h0);

        // Unmapped accesses
        pr_addr = 32'h0000_9000; pr_rd_en = 1'b1;
        step();
        bus_idle();
        check("err_rd_pulse", 32'(bus_err), ERR_EN ? 32'h1 : 32'h0);
        check("err_rd_rdata", pr_rdata, 32'h0);
        step();
        check("err_rd_end", 32'(bus_err), 32'h0);
        read_chk("err_addr_rd", 32'h7f8c, ERR_EN ? 32'h0000_9000 : 32'h0);
        check("err_mapped_none", 32'(bus_err), 32'h0);
        bus_write(32'h7f0c, 32'h5, 4'hf);
        check("err_wr_pulse", 32'(bus_err), ERR_EN ? 32'h1 : 32'h0);
        read_chk("err_addr_wr", 32'h7f8c, ERR_EN ? 32'h0000_7f0c : 32'h0);

        // Reset during a PEND read with PEND = 2'b11
        irq_in = 2'b11;
        step();
        step();
        read_chk("pre_rst_pend", 32'h7f80, 32'h3);
        reset = 1'b1; pr_addr = 32'h7f80; pr_rd_en = 1'b1;
        step();
        reset = 1'b0;
        bus_idle();
        irq_in = 2'b00;
        check("mid_rst_rdata", pr_rdata, 32'h0);
        check("mid_rst_hw",    32'(hw_int), 32'h0);
        read_chk("mid_rst_pend", 32'h7f80, 32'h0);
        read_chk("mid_rst_mask", 32'h7f88, 32'h3);

        // Reset discards a same-cycle MASK write
        reset = 1'b1; pr_addr = 32'h7f88; pr_wdata = 32'h0; pr_byteen = 4'hf;
        step();
        reset = 1'b0;
        bus_idle();
        read_chk("rst_wr_drop", 32'h7f88, 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
